slave_port_arbiter: RTL and testbench

SLAVE_PORT_ARBITER -- requirements
Module: slave_port_arbiter

---
 rtl/xbar_pkg.sv | 21 ++
 rtl/rr_priority_pick.sv | 37 +++
 rtl/slave_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_slave_port_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/xbar_pkg.sv
// Shared crossbar definitions: arbiter state encoding and default sizing.
// Users of this package: slave_port_arbiter (optional watchdog via
// SLAVE_PORT_ARBITER_TIMEOUT_EN) and rr_priority_pick.
package xbar_pkg;

  // Default number of requesting masters per slave port.
  localparam int unsigned NMastersDefault = 4;

  // Default number of un-acked grant cycles before the watchdog aborts.
  localparam int unsigned TimeoutCyclesDefault = 16;

  // Watchdog counter width; covers the full 1..255 timeout range.
  localparam int unsigned WdogWidth = 8;

  // Arbiter FSM: waiting for requests, or one master owns the slave.
  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StBusy = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin request picker. Priority starts at the master after last_idx
// and wraps, so the most recently served master is the lowest priority.
// Purely combinational.
module rr_priority_pick
  import xbar_pkg::*;
#(
  parameter int unsigned N_MASTERS = NMastersDefault,
  parameter int unsigned IdxW      = $clog2(N_MASTERS)
) (
  input  logic [N_MASTERS-1:0] req_i,
  input  logic [IdxW-1:0]      last_idx_i,
  output logic [N_MASTERS-1:0] pick_o,
  output logic [IdxW-1:0]      idx_o,
  output logic                 any_o
);

  // Scan N_MASTERS candidates starting one past last_idx; first requester wins.
  always_comb begin
    int unsigned cand;
    logic [IdxW-1:0] cand_idx;
    pick_o   = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned off = 1; off <= N_MASTERS; off++) begin
      cand     = (32'(last_idx_i) + off) % N_MASTERS;
      cand_idx = IdxW'(cand);
      if (!any_o && req_i[cand_idx]) begin
        any_o            = 1'b1;
        pick_o[cand_idx] = 1'b1;
        idx_o            = cand_idx;
      end
    end
  end

endmodule

// File: rtl/slave_port_arbiter.sv
// Per-slave-port arbiter for the crossbar. Grants one master at a time in
// round-robin order, holds the grant until the slave acks, then inserts one
// idle cycle before the next grant. Address decode is done outside.
// Optional watchdog abort: define SLAVE_PORT_ARBITER_TIMEOUT_EN.
module slave_port_arbiter
  import xbar_pkg::*;
#(
  parameter int unsigned N_MASTERS      = NMastersDefault,
  parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDefault
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_MASTERS-1:0]         req,
  input  logic                         slave_ack,
  output logic [N_MASTERS-1:0]         grant,
  output logic [$clog2(N_MASTERS)-1:0] grant_idx,
  output logic                         grant_valid,
  output logic [N_MASTERS-1:0]         master_ack,
  output logic                         timeout_err
);

  localparam int unsigned IdxW = $clog2(N_MASTERS);

  arb_state_e              state_q, state_d;
  logic [N_MASTERS-1:0]    grant_q, grant_d;
  logic [IdxW-1:0]         grant_idx_q, grant_idx_d;
  logic [IdxW-1:0]         last_idx_q, last_idx_d;
  logic [N_MASTERS-1:0]    pick;
  logic [IdxW-1:0]         pick_idx;
  logic                    pick_any;
  logic                    txn_end;

`ifdef SLAVE_PORT_ARBITER_TIMEOUT_EN
  localparam logic [WdogWidth-1:0] WdogLast = WdogWidth'(TIMEOUT_CYCLES - 1);

  logic [WdogWidth-1:0]    wdog_q, wdog_d;
  logic                    timeout_err_q, timeout_err_d;
`endif

  rr_priority_pick #(
    .N_MASTERS (N_MASTERS),
    .IdxW      (IdxW)
  ) u_pick (
    .req_i      (req),
    .last_idx_i (last_idx_q),
    .pick_o     (pick),
    .idx_o      (pick_idx),
    .any_o      (pick_any)
  );

  // Next-state: grant on a request in idle; end on ack (or watchdog) in busy.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    last_idx_d  = last_idx_q;
    txn_end     = 1'b0;
`ifdef SLAVE_PORT_ARBITER_TIMEOUT_EN
    wdog_d        = wdog_q;
    timeout_err_d = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (pick_any) begin
          state_d     = StBusy;
          grant_d     = pick;
          grant_idx_d = pick_idx;
`ifdef SLAVE_PORT_ARBITER_TIMEOUT_EN
          wdog_d      = '0;
`endif
        end
      end
      StBusy: begin
        // A coincident ack wins over the watchdog: normal completion.
        if (slave_ack) begin
          txn_end = 1'b1;
        end
`ifdef SLAVE_PORT_ARBITER_TIMEOUT_EN
        else if (wdog_q == WdogLast) begin
          txn_end       = 1'b1;
          timeout_err_d = 1'b1;
        end else begin
          wdog_d = wdog_q + WdogWidth'(1);
        end
`endif
        if (txn_end) begin
          state_d     = StIdle;
          grant_d     = '0;
          grant_idx_d = '0;
          last_idx_d  = grant_idx_q;
`ifdef SLAVE_PORT_ARBITER_TIMEOUT_EN
          wdog_d      = '0;
`endif
        end
      end
      default: begin
        state_d     = StIdle;
        grant_d     = '0;
        grant_idx_d = '0;
      end
    endcase
  end

  // FSM and registered outputs; reset parks priority so master 0 goes first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      grant_q       <= '0;
      grant_idx_q   <= '0;
      last_idx_q    <= IdxW'(N_MASTERS - 1);
`ifdef SLAVE_PORT_ARBITER_TIMEOUT_EN
      wdog_q        <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_idx_q   <= grant_idx_d;
      last_idx_q    <= last_idx_d;
`ifdef SLAVE_PORT_ARBITER_TIMEOUT_EN
      wdog_q        <= wdog_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = grant_idx_q;
  assign grant_valid = |grant_q;
  // grant_q is zero while idle, so acks outside a transaction reach nobody.
  assign master_ack  = grant_q & {N_MASTERS{slave_ack}};

`ifdef SLAVE_PORT_ARBITER_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_err        = 1'b0;
`endif

endmodule

// File: tb/tb_slave_port_arbiter.sv
// Directed bench for slave_port_arbiter (N_MASTERS=4, TIMEOUT_CYCLES=8).
// Watchdog scenarios follow SLAVE_PORT_ARBITER_TIMEOUT_EN.
module tb_slave_port_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       slave_ack;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_valid;
  logic [3:0] master_ack;
  logic       timeout_err;

  int checks   = 0;
  int failures = 0;

  slave_port_arbiter #(
    .N_MASTERS      (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .slave_ack   (slave_ack),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .master_ack  (master_ack),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] exp_g;
    logic       bad;
    rst       = 1'b1;
    req       = 4'b0000;
    slave_ack = 1'b0;
    bad       = 1'b0;
    tick();
    tick();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_idx", 32'(grant_idx), 32'h0);
    check("rst_valid", 32'(grant_valid), 32'h0);
    check("rst_terr", 32'(timeout_err), 32'h0);
    check("rst_mack", 32'(master_ack), 32'h0);
    rst = 1'b0;

    // All masters requesting: 0001,0010,0100,1000,0001 with an idle gap each.
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      exp_g = 4'b0001 << (i % 4);
      tick();
      check("rr_grant", 32'(grant), 32'(exp_g));
      check("rr_idx", 32'(grant_idx), 32'(i % 4));
      check("rr_valid", 32'(grant_valid), 32'h1);
      check("rr_onehot", 32'($onehot(grant)), 32'h1);
      tick();
      slave_ack = 1'b1;
      #1;
      check("rr_mack", 32'(master_ack), 32'(exp_g));
      tick();
      slave_ack = 1'b0;
      check("rr_gap", 32'(grant), 32'h0);
      if (i == 4) req = 4'b0000;
    end
    tick();
    check("idle_no_req", 32'(grant), 32'h0);

    // Single requester, ack three cycles after grant.
    req = 4'b0100;
    tick();
    check("single_grant", 32'(grant), 32'h4);
    check("single_idx", 32'(grant_idx), 32'h2);
    tick();
    tick();
    tick();
    slave_ack = 1'b1;
    #1;
    check("single_mack", 32'(master_ack), 32'h4);
    check("single_hold", 32'(grant), 32'h4);
    tick();
    slave_ack = 1'b0;
    req       = 4'b0000;
    #1;
    check("single_done", 32'(grant), 32'h0);
    check("single_mack_off", 32'(master_ack), 32'h0);

    // Requester drops mid-transaction; grant must hold until ack.
    req = 4'b0100;
    tick();
    check("drop_grant", 32'(grant), 32'h4);
    req = 4'b0001;
    tick();
    tick();
    tick();
    check("drop_hold", 32'(grant), 32'h4);
    slave_ack = 1'b1;
    #1;
    check("drop_mack", 32'(master_ack), 32'h4);
    tick();
    slave_ack = 1'b0;
    check("drop_gap", 32'(grant), 32'h0);
    tick();
    check("drop_next", 32'(grant), 32'h1);
    check("drop_next_idx", 32'(grant_idx), 32'h0);
    tick();
    slave_ack = 1'b1;
    tick();
    slave_ack = 1'b0;
    req       = 4'b0000;
    tick();

`ifdef SLAVE_PORT_ARBITER_TIMEOUT_EN
    // Eight un-acked busy cycles abort the transaction.
    req = 4'b0010;
    tick();
    check("wd_grant", 32'(grant), 32'h2);
    repeat (7) tick();
    check("wd_pre_grant", 32'(grant), 32'h2);
    check("wd_pre_terr", 32'(timeout_err), 32'h0);
    tick();
    check("wd_abort_grant", 32'(grant), 32'h0);
    check("wd_abort_terr", 32'(timeout_err), 32'h1);
    req = 4'b0000;
    tick();
    check("wd_pulse_end", 32'(timeout_err), 32'h0);

    // Ack on the eighth cycle wins over the watchdog.
    req = 4'b0100;
    tick();
    check("wd_ack_grant", 32'(grant), 32'h4);
    repeat (7) tick();
    slave_ack = 1'b1;
    #1;
    check("wd_ack_mack", 32'(master_ack), 32'h4);
    tick();
    slave_ack = 1'b0;
    req       = 4'b0000;
    check("wd_ack_done", 32'(grant), 32'h0);
    check("wd_ack_terr", 32'(timeout_err), 32'h0);
    tick();
    check("wd_ack_terr2", 32'(timeout_err), 32'h0);
`else
    // Without the watchdog the grant waits indefinitely.
    req = 4'b0010;
    tick();
    check("hold_grant", 32'(grant), 32'h2);
    repeat (100) begin
      tick();
      if (grant !== 4'b0010 || timeout_err !== 1'b0) bad = 1'b1;
    end
    check("hold_100", 32'(bad), 32'h0);
    check("hold_terr", 32'(timeout_err), 32'h0);
    slave_ack = 1'b1;
    tick();
    slave_ack = 1'b0;
    req       = 4'b0000;
    check("hold_release", 32'(grant), 32'h0);
    tick();
`endif

    // Reset while busy drops the grant; priority restarts at master 0.
    req = 4'b0010;
    tick();
    check("rstb_grant", 32'(grant), 32'h2);
    tick();
    rst = 1'b1;
    req = 4'b1111;
    tick();
    check("rstb_drop", 32'(grant), 32'h0);
    check("rstb_valid", 32'(grant_valid), 32'h0);
    check("rstb_mack", 32'(master_ack), 32'h0);
    check("rstb_terr", 32'(timeout_err), 32'h0);
    rst = 1'b0;
    tick();
    check("rstb_first", 32'(grant), 32'h1);
    check("rstb_terr2", 32'(timeout_err), 32'h0);
    tick();
    slave_ack = 1'b1;
    #1;
    check("rstb_mack2", 32'(master_ack), 32'h1);
    tick();
    slave_ack = 1'b0;
    req       = 4'b0000;
    tick();

    // Ack in idle reaches no master and changes nothing.
    slave_ack = 1'b1;
    #1;
    check("idle_ack_mack", 32'(master_ack), 32'h0);
    tick();
    slave_ack = 1'b0;
    check("idle_ack_grant", 32'(grant), 32'h0);
    check("idle_ack_terr", 32'(timeout_err), 32'h0);
    req = 4'b0001;
    tick();
    check("idle_ack_next", 32'(grant), 32'h1);
    tick();
    slave_ack = 1'b1;
    tick();
    slave_ack = 1'b0;
    req       = 4'b0000;
    check("final_idle", 32'(grant), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
